// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the RAM port arbiter and the CPU memory interface:
// default bus widths, arbitration limits, the access-cycle state encoding and
// the owner codes driven to the status LEDs.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   localparam int ADDR_W_DEF        = 8;
   localparam int DATA_W_DEF        = 16;
   localparam int DMA_MAX_BURST_DEF = 4;
   localparam int STARVE_LIMIT_DEF  = 3;

   // Who owns the RAM port in the current access cycle.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CPU  = 2'd1,
      ST_DMA  = 2'd2
   } arb_state_t;

   localparam logic [1:0] OWNER_IDLE = 2'b00;
   localparam logic [1:0] OWNER_CPU  = 2'b01;
   localparam logic [1:0] OWNER_DMA  = 2'b10;

   function automatic logic [1:0] owner_code(input arb_state_t state);
      case (state)
         ST_CPU:  return OWNER_CPU;
         ST_DMA:  return OWNER_DMA;
         default: return OWNER_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/mem_arb_prio_sel.sv
// -----------------------------------------------------------------------------
// mem_arb_prio_sel
// Purely combinational decision function: picks the owner of the next access
// cycle from the two requests, the current owner and the burst/starvation
// counters.
//
// Ports:
//   i_cpu_req     CPU request
//   i_dma_req     DMA request
//   i_state       owner of the current access cycle
//   i_burst_cnt   consecutive DMA grants in the current burst
//   i_starve_cnt  consecutive cycles DMA has lost to the CPU
//   o_next_state  owner of the next access cycle
// -----------------------------------------------------------------------------
module mem_arb_prio_sel
   import mem_port_arbiter_pkg::*;
#(
   parameter int DMA_MAX_BURST = DMA_MAX_BURST_DEF,
   parameter int STARVE_LIMIT  = STARVE_LIMIT_DEF,
   parameter int BURST_W       = $clog2(DMA_MAX_BURST + 1),
   parameter int STARVE_W      = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                i_cpu_req,
   input  logic                i_dma_req,
   input  arb_state_t          i_state,
   input  logic [BURST_W-1:0]  i_burst_cnt,
   input  logic [STARVE_W-1:0] i_starve_cnt,
   output arb_state_t          o_next_state
);

   localparam logic [BURST_W-1:0]  C_BURST_MAX  = BURST_W'(DMA_MAX_BURST);
   localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   logic w_starved;
   logic w_burst_hold;

   // DMA has waited long enough: it goes ahead of the CPU unconditionally.
   assign w_starved    = i_dma_req && (i_starve_cnt == C_STARVE_MAX);
   // An unfinished DMA burst keeps the port even while the CPU is asking.
   assign w_burst_hold = (i_state == ST_DMA) && (i_burst_cnt < C_BURST_MAX) && i_dma_req;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the if-chain can leave it unassigned and infer a latch.
   always_comb begin
      o_next_state = ST_IDLE;
      if (w_starved) begin
         o_next_state = ST_DMA;
      end else if (i_cpu_req && !w_burst_hold) begin
         o_next_state = ST_CPU;
      end else if (i_dma_req) begin
         o_next_state = ST_DMA;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single synchronous-RAM port between the CPU and a DMA/program
// loader. CPU wins by default; DMA gets bounded bursts and a starvation counter
// forces it ahead of the CPU after repeated losses.
//
// Timing: requests sampled in cycle t, winner's address/we/wdata registered at
// the end of t; gnt is high and the RAM accesses in t+1; rvalid in t+2 (reads).
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata       CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid         CPU grant pulse, CPU read data valid
//   dma_req/we/addr/wdata       DMA request, held until dma_gnt
//   dma_gnt, dma_rvalid         DMA grant pulse, DMA read data valid
//   mem_addr/we/wdata           registered RAM controls
//   mem_rdata                   RAM read data (1 cycle after access)
//   owner                       current access cycle owner (00/01/10)
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int DMA_MAX_BURST = DMA_MAX_BURST_DEF,
   parameter int STARVE_LIMIT  = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner
);

   localparam int BURST_W  = $clog2(DMA_MAX_BURST + 1);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [BURST_W-1:0]  C_BURST_MAX  = BURST_W'(DMA_MAX_BURST);
   localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   arb_state_t          r_state;
   arb_state_t          w_next_state;
   logic [BURST_W-1:0]  r_burst_cnt;
   logic [BURST_W-1:0]  w_burst_nxt;
   logic [STARVE_W-1:0] r_starve_cnt;
   logic [STARVE_W-1:0] w_starve_nxt;

   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;

   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_we;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_cpu_rvalid;
   logic                r_dma_rvalid;

   // ---------------------------------------------------------------- next state
   mem_arb_prio_sel #(
      .DMA_MAX_BURST (DMA_MAX_BURST),
      .STARVE_LIMIT  (STARVE_LIMIT),
      .BURST_W       (BURST_W),
      .STARVE_W      (STARVE_W)
   ) u_prio_sel (
      .i_cpu_req    (cpu_req),
      .i_dma_req    (dma_req),
      .i_state      (r_state),
      .i_burst_cnt  (r_burst_cnt),
      .i_starve_cnt (r_starve_cnt),
      .o_next_state (w_next_state)
   );

   // Winner's request mux and counter updates for the next access cycle.
   always_comb begin
      w_sel_we     = 1'b0;
      w_sel_addr   = r_mem_addr;
      w_sel_wdata  = r_mem_wdata;
      w_burst_nxt  = '0;
      w_starve_nxt = '0;

      case (w_next_state)
         ST_CPU: begin
            w_sel_we    = cpu_we;
            w_sel_addr  = cpu_addr;
            w_sel_wdata = cpu_wdata;
         end
         ST_DMA: begin
            w_sel_we    = dma_we;
            w_sel_addr  = dma_addr;
            w_sel_wdata = dma_wdata;
         end
         default: ;
      endcase

      // A burst restarts at 1 whenever DMA takes the port from CPU or IDLE,
      // which also covers the forced (starvation) grant.
      if (w_next_state == ST_DMA) begin
         if (r_state != ST_DMA) begin
            w_burst_nxt = BURST_W'(1);
         end else if (r_burst_cnt != C_BURST_MAX) begin
            w_burst_nxt = r_burst_cnt + BURST_W'(1);
         end else begin
            w_burst_nxt = r_burst_cnt;
         end
      end

      if (dma_req && (w_next_state == ST_CPU)) begin
         w_starve_nxt = (r_starve_cnt != C_STARVE_MAX) ? r_starve_cnt + STARVE_W'(1)
                                                       : r_starve_cnt;
      end
   end

   // ------------------------------------------------------------ state register
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_burst_cnt  <= '0;
         r_starve_cnt <= '0;
         r_mem_addr   <= '0;
         r_mem_we     <= 1'b0;
         r_mem_wdata  <= '0;
         r_cpu_rvalid <= 1'b0;
         r_dma_rvalid <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_burst_cnt  <= w_burst_nxt;
         r_starve_cnt <= w_starve_nxt;
         r_mem_addr   <= w_sel_addr;
         r_mem_we     <= w_sel_we;
         r_mem_wdata  <= w_sel_wdata;
         // Read data returns one cycle after the access cycle.
         r_cpu_rvalid <= (r_state == ST_CPU) && !r_mem_we;
         r_dma_rvalid <= (r_state == ST_DMA) && !r_mem_we;
      end
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      cpu_gnt = (r_state == ST_CPU);
      dma_gnt = (r_state == ST_DMA);
      owner   = owner_code(r_state);
   end

   assign cpu_rvalid = r_cpu_rvalid;
   assign dma_rvalid = r_dma_rvalid;
   assign mem_addr   = r_mem_addr;
   assign mem_we     = r_mem_we;
   assign mem_wdata  = r_mem_wdata;

   // The read data is consumed by the requesters directly from the RAM bus.
   logic w_unused_rdata;
   assign w_unused_rdata = ^mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a 256x16 synchronous RAM model.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [7:0]  cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_gnt, cpu_rvalid;
   logic        dma_req, dma_we;
   logic [7:0]  dma_addr;
   logic [15:0] dma_wdata;
   logic        dma_gnt, dma_rvalid;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic [1:0]  owner;

   logic [15:0] ram [256];
   int          n_pass = 0;
   int          n_total = 0;
   int          both_gnt_cycles = 0;

   mem_port_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .owner      (owner)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: read data registered, write on the access cycle.
   always @(posedge clk) begin
      mem_rdata = ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
   end

   always @(negedge clk) begin
      if (cpu_gnt && dma_gnt) both_gnt_cycles++;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_total++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
      ram[8'h10] = 16'hABCD;
      for (int i = 0; i < 4; i++) ram[i] = 16'h1000 + 16'(i);

      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;

      // ---- reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctrl", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_we, owner}, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      @(negedge clk) reset = 1'b0;
      tick();
      check("idle_owner", owner, 2'b00);

      // ---- single CPU read of 0x10
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      tick();
      check("rd_cpu_gnt", {cpu_gnt, dma_gnt}, 2'b10);
      check("rd_mem_addr", mem_addr, 8'h10);
      check("rd_owner", owner, 2'b01);
      cpu_req = 0;
      tick();
      check("rd_rvalid", {cpu_rvalid, dma_rvalid, cpu_gnt}, 3'b100);
      check("rd_data", mem_rdata, 16'hABCD);
      tick();
      check("rd_rvalid_end", cpu_rvalid, 0);

      // ---- simultaneous writes from IDLE: CPU first, DMA next
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 16'h1111;
      dma_req = 1; dma_we = 1; dma_addr = 8'h21; dma_wdata = 16'h2222;
      tick();
      check("sim_cpu_first", {cpu_gnt, dma_gnt}, 2'b10);
      check("sim_cpu_bus", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h20, 16'h1111});
      cpu_req = 0; cpu_we = 0;
      tick();
      check("sim_dma_next", {cpu_gnt, dma_gnt, owner}, {2'b01, 2'b10});
      check("sim_dma_bus", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h21, 16'h2222});
      dma_req = 0; dma_we = 0;
      tick();
      check("sim_idle", {owner, mem_we, cpu_rvalid, dma_rvalid}, 0);
      check("sim_ram20", ram[8'h20], 16'h1111);
      check("sim_ram21", ram[8'h21], 16'h2222);

      // ---- starvation: DMA forced in after exactly 3 CPU grants
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
      dma_req = 1; dma_we = 0; dma_addr = 8'h40;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("starve_cpu%0d", i), {cpu_gnt, dma_gnt}, 2'b10);
         check($sformatf("starve_addr%0d", i), mem_addr, 8'h30 + 8'(i));
         cpu_addr = 8'h31 + 8'(i);
      end
      tick();
      check("starve_dma", {cpu_gnt, dma_gnt}, 2'b01);
      check("starve_dma_addr", mem_addr, 8'h40);
      check("starve_cpu_rv", cpu_rvalid, 1);
      dma_req = 0;
      tick();
      check("starve_cpu_back", {cpu_gnt, dma_gnt, dma_rvalid}, 3'b101);
      check("starve_cpu_addr", mem_addr, 8'h33);
      cpu_req = 0;
      tick();

      // ---- DMA burst bound: 4 DMA, 1 CPU, DMA resumes
      dma_req = 1; dma_we = 1; dma_addr = 8'h50; dma_wdata = 16'h5000;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("burst_dma%0d", i), {cpu_gnt, dma_gnt}, 2'b01);
         check($sformatf("burst_addr%0d", i), mem_addr, 8'h50 + 8'(i));
         if (i == 0) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = 8'h60;
         end
         dma_addr  = 8'h51 + 8'(i);
         dma_wdata = 16'h5001 + 16'(i);
      end
      tick();
      check("burst_cpu", {cpu_gnt, dma_gnt}, 2'b10);
      check("burst_cpu_addr", mem_addr, 8'h60);
      cpu_req = 0;
      for (int i = 4; i < 8; i++) begin
         tick();
         check($sformatf("burst_resume%0d", i), {cpu_gnt, dma_gnt}, 2'b01);
         check($sformatf("burst_raddr%0d", i), mem_addr, 8'h50 + 8'(i));
         if (i == 7) begin
            dma_req = 0; dma_we = 0;
         end else begin
            dma_addr  = 8'h51 + 8'(i);
            dma_wdata = 16'h5001 + 16'(i);
         end
      end
      tick();
      check("burst_idle", owner, 2'b00);
      check("burst_ram50", ram[8'h50], 16'h5000);
      check("burst_ram57", ram[8'h57], 16'h5007);

      // ---- back-to-back CPU reads 0x00..0x03
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h00;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i < 4) begin
            check($sformatf("b2b_gnt%0d", i), cpu_gnt, 1);
            check($sformatf("b2b_addr%0d", i), mem_addr, 8'(i));
         end else begin
            check("b2b_gnt_end", cpu_gnt, 0);
         end
         if (i > 0) begin
            check($sformatf("b2b_rv%0d", i), cpu_rvalid, 1);
            check($sformatf("b2b_data%0d", i), mem_rdata, 16'h1000 + 16'(i - 1));
         end
         if (i < 3) cpu_addr = 8'(i + 1);
         else cpu_req = 0;
      end
      tick();
      check("b2b_rv_end", cpu_rvalid, 0);

      // ---- reset during a DMA write grant cycle
      dma_req = 1; dma_we = 1; dma_addr = 8'h70; dma_wdata = 16'h7777;
      tick();
      check("mid_dma_gnt", dma_gnt, 1);
      reset = 1'b1;
      dma_req = 0; dma_we = 0;
      #1;
      check("mid_rst_ctrl", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_we, owner}, 0);
      check("mid_rst_bus", {mem_addr, mem_wdata}, 0);
      tick();
      check("mid_no_write", ram[8'h70], 16'h0000);
      @(negedge clk) reset = 1'b0;
      tick();
      check("post_rst_idle", {owner, mem_we, cpu_rvalid, dma_rvalid}, 0);
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      tick();
      check("post_rst_gnt", {cpu_gnt, dma_gnt}, 2'b10);
      cpu_req = 0;
      tick();
      check("post_rst_data", {cpu_rvalid, mem_rdata}, {1'b1, 16'hABCD});

      check("never_both_gnt", both_gnt_cycles, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
